// File: rtl/if_pkg.sv
// Shared constants and the fetch packet type used by the instruction-fetch stage.
package if_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer: an output register toward the consumer plus one
// overflow slot that catches a beat arriving while the output is stalled.
module fetch_skid_buffer
    import if_pkg::*;
#(
    parameter type pkt_t = fetch_pkt_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  pkt_t in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output pkt_t out_data_o
);

    // Valid/ready: a beat moves on a rising edge where valid && ready are both 1;
    // while valid is high and ready is low the producer holds valid and data stable.

    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    pkt_t out_data_q, out_data_d;
    pkt_t skid_data_q, skid_data_d;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            // Output slot frees up this edge; the skid entry is older, so it goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid_i;
                if (in_valid_i) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (in_valid_i && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues reads to a synchronous
// instruction memory, and hands {pc, instr} packets to decode.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_instr,
    output logic               misalign_err
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            misalign_q, misalign_d;
    logic            ret_valid, skid_ready, will_fill;
    fetch_pkt_t      ret_pkt, out_pkt;

    // A redirect kills whatever read returns in the same cycle.
    assign ret_valid = inflight_q && !redirect_valid;
    assign ret_pkt   = '{pc: req_pc_q, instr: imem_rdata};

    // A return that lands in the skid this edge leaves no room for a read issued
    // now, so issue also waits for a skid that is about to fill.
    assign will_fill = ret_valid && out_valid && !out_ready;
    assign imem_en   = reset && skid_ready && !will_fill && !misalign_q && !redirect_valid;
    assign imem_addr = pc_q[IMEM_AW+1:2];

    assign out_pc       = out_pkt.pc;
    assign out_instr    = out_pkt.instr;
    assign misalign_err = misalign_q;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_en;
        misalign_d = misalign_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            misalign_d = (redirect_pc[1:0] != 2'b00);
        end else if (imem_en) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_skid_buffer #(
        .pkt_t (fetch_pkt_t)
    ) u_skid (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (redirect_valid),
        .in_valid_i  (ret_valid),
        .in_ready_o  (skid_ready),
        .in_data_i   (ret_pkt),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_pkt)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a random
// backpressure/redirect phase, scored against the in-order program stream.
module tb_if_fetch_stage;

    localparam int          AW     = 10;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = 32'h0;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          misalign_err;

    int n_checks = 0;
    int n_errs   = 0;
    int pkt_cnt  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC (RST_PC),
        .IMEM_AW  (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .misalign_err   (misalign_err)
    );

    // Synchronous-read instruction memory: word i holds A000_0000 | i.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'hA000_0000 | {22'd0, imem_addr};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return 32'hA000_0000 | ((pc >> 2) & 32'h3FF);
    endfunction

    // Reference stream: after a (re)start at pc, decode must see pc, pc+4, ... in order.
    task automatic push_from(input logic [31:0] start);
        logic [31:0] pc;
        exp_q.delete();
        pc = start;
        for (int i = 0; i < 200; i++) begin
            exp_q.push_back({pc, exp_instr(pc)});
            pc = pc + 32'd4;
        end
    endtask

    // Monitor: any valid packet must be the next one in the reference stream.
    always @(negedge clk) begin
        logic [63:0] head;
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_pkt: got pc %h instr %h, required no packet", out_pc, out_instr);
            end else begin
                head = exp_q[0];
                check("pkt_pc", out_pc, head[63:32]);
                check("pkt_instr", out_instr, head[31:0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pkt_cnt++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset low for 'cycles' edges, checks reset state, then the 3-cycle latency.
    task automatic reset_and_check(input int cycles);
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_misalign", misalign_err, 0);
        check("rst_imem_en", imem_en, 0);
        push_from(RST_PC);
        pkt_cnt = 0;
        reset = 1'b1;
        @(negedge clk);
        check("lat_c1_imem_en", imem_en, 1);
        check("lat_c1_imem_addr", imem_addr, RST_PC[AW+1:2]);
        check("lat_c1_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat_c2_out_valid", out_valid, 0);
        @(negedge clk);
        check("lat_c3_out_valid", out_valid, 1);
        check("lat_c3_out_pc", out_pc, RST_PC);
    endtask

    // Runs with out_ready=1 until target is accepted; returns just after the next edge.
    task automatic wait_pc(input logic [31:0] target);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_pc == target) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_errs++;
            $display("FAIL wait_pc: pc %h not delivered within 60 cycles, required delivery", target);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", n_errs + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset, latency and streaming throughput.
        reset_and_check(3);
        repeat (17) @(negedge clk);
        tick();
        check("stream_count", pkt_cnt, 18);

        // Backpressure while pc 8 is presented.
        reset_and_check(2);
        wait_pc(32'h4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_pc", out_pc, 32'h8);
            check("bp_out_instr", out_instr, 32'hA000_0002);
            if (i > 0) check("bp_imem_en", imem_en, 0);
        end
        tick();
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        tick();

        // Redirect while pc 0x10 is stalled; same-cycle handshake is squashed.
        reset_and_check(2);
        wait_pc(32'hC);
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rd_stall_pc", out_pc, 32'h10);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        push_from(32'h100);
        @(negedge clk);
        check("rd_flush_valid", out_valid, 0);
        repeat (10) @(negedge clk);
        tick();

        // Misaligned redirect halts fetch until an aligned redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        exp_q.delete();
        repeat (6) begin
            @(negedge clk);
            check("mis_err", misalign_err, 1);
            check("mis_imem_en", imem_en, 0);
            check("mis_out_valid", out_valid, 0);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        push_from(32'h200);
        @(negedge clk);
        check("mis_clear", misalign_err, 0);
        check("mis_resume_en", imem_en, 1);
        tick();

        // Reset mid-stream with the skid full.
        wait_pc(32'h240);
        out_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("mr_stall_pc", out_pc, 32'h244);
            check("mr_imem_en", imem_en, 0);
        end
        tick();
        out_ready = 1'b1;
        reset_and_check(1);
        repeat (6) @(negedge clk);
        tick();

        // Random backpressure and aligned redirects.
        for (int c = 0; c < 400; c++) begin
            if (redirect_valid) begin
                push_from(redirect_pc);
                redirect_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'($urandom_range(0, 1023)) << 2;
            end
            tick();
        end
        if (redirect_valid) begin
            push_from(redirect_pc);
            redirect_valid = 1'b0;
        end
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
